// File: rtl/rv32im_regfile_ctrl_pkg.sv
// Shared types for the RV32IM register file controller: read FSM encoding
// and the register-count helper used to size the pending scoreboard.
package rv32im_regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    function automatic int num_regs(input int reg_bits);
        return 1 << reg_bits;
    endfunction

endpackage

// File: rtl/rv32im_regfile_ctrl_if.sv
// Bundle of the read-request, writeback, mul/div and register-file signals.
// master drives the requests (core side), slave is the controller.
interface rv32im_regfile_ctrl_if #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
);
    logic                rd_req_i;
    logic [REG_BITS-1:0] rd_rs1_i;
    logic [REG_BITS-1:0] rd_rs2_i;
    logic                rd_ack_o;
    logic                rd_valid_o;
    logic                wb_valid_i;
    logic [REG_BITS-1:0] wb_addr_i;
    logic [XLEN-1:0]     wb_data_i;
    logic                wb_ready_o;
    logic                md_issue_i;
    logic [REG_BITS-1:0] md_rd_i;
    logic                md_valid_i;
    logic [REG_BITS-1:0] md_addr_i;
    logic [XLEN-1:0]     md_data_i;
    logic                md_ready_o;
    logic                reg_write_o;
    logic [REG_BITS-1:0] reg_rd_addr_o;
    logic [XLEN-1:0]     reg_data_o;
    logic                reg_read_o;
    logic [REG_BITS-1:0] reg_rs1_addr_o;
    logic [REG_BITS-1:0] reg_rs2_addr_o;
    logic                busy_o;

    modport master (
        output rd_req_i, rd_rs1_i, rd_rs2_i,
        output wb_valid_i, wb_addr_i, wb_data_i,
        output md_issue_i, md_rd_i, md_valid_i, md_addr_i, md_data_i,
        input  rd_ack_o, rd_valid_o, wb_ready_o, md_ready_o,
        input  reg_write_o, reg_rd_addr_o, reg_data_o,
        input  reg_read_o, reg_rs1_addr_o, reg_rs2_addr_o, busy_o
    );

    modport slave (
        input  rd_req_i, rd_rs1_i, rd_rs2_i,
        input  wb_valid_i, wb_addr_i, wb_data_i,
        input  md_issue_i, md_rd_i, md_valid_i, md_addr_i, md_data_i,
        output rd_ack_o, rd_valid_o, wb_ready_o, md_ready_o,
        output reg_write_o, reg_rd_addr_o, reg_data_o,
        output reg_read_o, reg_rs1_addr_o, reg_rs2_addr_o, busy_o
    );
endinterface

// File: rtl/rv32im_scoreboard.sv
// Pending-destination bit vector for outstanding mul/div results, with a
// registered busy flag and two combinational lookup ports.
module rv32im_scoreboard
    import rv32im_regfile_ctrl_pkg::*;
#(
    parameter int REG_BITS = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                set_en_i,
    input  logic [REG_BITS-1:0] set_addr_i,
    input  logic                clr_en_i,
    input  logic [REG_BITS-1:0] clr_addr_i,
    input  logic [REG_BITS-1:0] rs1_addr_i,
    input  logic [REG_BITS-1:0] rs2_addr_i,
    output logic                rs1_pend_o,
    output logic                rs2_pend_o,
    output logic                busy_o
);
    localparam int NUM_REGS = num_regs(REG_BITS);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Set is applied after clear so a same-cycle issue/retire keeps the bit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i) set_mask[set_addr_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
        pend_d    = (pend_q & ~clr_mask) | set_mask;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            busy_o <= 1'b0;
        end else begin
            pend_q <= pend_d;
            busy_o <= |pend_d;
        end
    end

    assign rs1_pend_o = pend_q[rs1_addr_i];
    assign rs2_pend_o = pend_q[rs2_addr_i];

endmodule

// File: rtl/rv32im_regfile_ctrl.sv
// RV32IM register file sequencer: arbitrates the single write port between
// writeback and mul/div, and issues hazard-free operand reads to the BRAMs.
module rv32im_regfile_ctrl
    import rv32im_regfile_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    rv32im_regfile_ctrl_if.slave  bus
);
    logic                acc_valid;
    logic [REG_BITS-1:0] acc_addr;
    logic [XLEN-1:0]     acc_data;
    logic                rs1_pend;
    logic                rs2_pend;
    logic                rs1_hazard;
    logic                rs2_hazard;
    rd_state_e           state;

    // Mul/div has fixed priority; ready is suppressed while reset is held.
    assign bus.md_ready_o = rst_ni & bus.md_valid_i;
    assign bus.wb_ready_o = rst_ni & bus.wb_valid_i & ~bus.md_valid_i;
    assign acc_valid      = bus.md_ready_o | bus.wb_ready_o;
    assign acc_addr       = bus.md_valid_i ? bus.md_addr_i : bus.wb_addr_i;
    assign acc_data       = bus.md_valid_i ? bus.md_data_i : bus.wb_data_i;

    rv32im_scoreboard #(
        .REG_BITS (REG_BITS)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_en_i   (bus.md_issue_i),
        .set_addr_i (bus.md_rd_i),
        .clr_en_i   (bus.md_ready_o),
        .clr_addr_i (bus.md_addr_i),
        .rs1_addr_i (bus.reg_rs1_addr_o),
        .rs2_addr_i (bus.reg_rs2_addr_o),
        .rs1_pend_o (rs1_pend),
        .rs2_pend_o (rs2_pend),
        .busy_o     (bus.busy_o)
    );

    // A write accepted now or sitting on the write port blocks the read, so
    // the BRAM never sees a same-edge write/read to one address.
    assign rs1_hazard = (bus.reg_rs1_addr_o != '0) &&
                        (rs1_pend ||
                         (acc_valid && (acc_addr == bus.reg_rs1_addr_o)) ||
                         (bus.reg_write_o && (bus.reg_rd_addr_o == bus.reg_rs1_addr_o)));
    assign rs2_hazard = (bus.reg_rs2_addr_o != '0) &&
                        (rs2_pend ||
                         (acc_valid && (acc_addr == bus.reg_rs2_addr_o)) ||
                         (bus.reg_write_o && (bus.reg_rd_addr_o == bus.reg_rs2_addr_o)));

    // Write issue stage: accepted write is presented for exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.reg_write_o   <= 1'b0;
            bus.reg_rd_addr_o <= '0;
            bus.reg_data_o    <= '0;
        end else begin
            bus.reg_write_o <= acc_valid && (acc_addr != '0);
            if (acc_valid) begin
                bus.reg_rd_addr_o <= acc_addr;
                bus.reg_data_o    <= acc_data;
            end
        end
    end

    assign bus.rd_ack_o = rst_ni & (state == ST_IDLE) & bus.rd_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= ST_IDLE;
            bus.reg_read_o     <= 1'b0;
            bus.rd_valid_o     <= 1'b0;
            bus.reg_rs1_addr_o <= '0;
            bus.reg_rs2_addr_o <= '0;
        end else begin
            bus.reg_read_o <= 1'b0;
            bus.rd_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rd_req_i) begin
                        bus.reg_rs1_addr_o <= bus.rd_rs1_i;
                        bus.reg_rs2_addr_o <= bus.rd_rs2_i;
                        state              <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!rs1_hazard && !rs2_hazard) begin
                        bus.reg_read_o <= 1'b1;
                        state          <= ST_READ;
                    end
                end
                ST_READ: begin
                    bus.rd_valid_o <= 1'b1;
                    state          <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32im_regfile_ctrl.sv
// Scoreboard bench for rv32im_regfile_ctrl: directed stimulus pushes expected
// writes/reads into queues; a negedge monitor pops and compares.
module tb_rv32im_regfile_ctrl;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    typedef struct {
        int          rd_cyc;
        int          vld_cyc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
    } rd_exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_rd_cyc = -1;
    int   c;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    logic [31:0] mem [32] = '{default: 32'h0};
    logic [31:0] q1;
    logic [31:0] q2;

    rv32im_regfile_ctrl_if #(.XLEN(32), .REG_BITS(5)) bus ();

    rv32im_regfile_ctrl #(
        .XLEN     (32),
        .REG_BITS (5)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-BRAM model without write-through: read returns the old contents.
    always @(posedge clk) begin
        if (bus.reg_write_o) mem[bus.reg_rd_addr_o] <= bus.reg_data_o;
        if (bus.reg_read_o) begin
            q1 <= mem[bus.reg_rs1_addr_o];
            q2 <= mem[bus.reg_rs2_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.reg_read_o) begin
                last_rd_cyc = cyc;
                chk("read_write_collision",
                    {31'd0, bus.reg_write_o &&
                     ((bus.reg_rd_addr_o == bus.reg_rs1_addr_o) ||
                      (bus.reg_rd_addr_o == bus.reg_rs2_addr_o))}, 32'd0);
            end
            if (bus.reg_write_o) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h at cycle %0d expected none",
                             bus.reg_rd_addr_o, bus.reg_data_o, cyc);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    chk("write_cycle", cyc, w.cyc);
                    chk("write_addr", {27'd0, bus.reg_rd_addr_o}, {27'd0, w.addr});
                    chk("write_data", bus.reg_data_o, w.data);
                end
            end
            if (bus.rd_valid_o) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd_valid: got rd_valid at cycle %0d expected none", cyc);
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    chk("rd_valid_cycle", cyc, r.vld_cyc);
                    chk("reg_read_cycle", last_rd_cyc, r.rd_cyc);
                    chk("rs1_addr", {27'd0, bus.reg_rs1_addr_o}, {27'd0, r.rs1});
                    chk("rs2_addr", {27'd0, bus.reg_rs2_addr_o}, {27'd0, r.rs2});
                    chk("rs1_data", q1, r.d1);
                    chk("rs2_data", q2, r.d2);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_req_i   = 1'b0;
        bus.rd_rs1_i   = '0;
        bus.rd_rs2_i   = '0;
        bus.wb_valid_i = 1'b0;
        bus.wb_addr_i  = '0;
        bus.wb_data_i  = '0;
        bus.md_issue_i = 1'b0;
        bus.md_rd_i    = '0;
        bus.md_valid_i = 1'b0;
        bus.md_addr_i  = '0;
        bus.md_data_i  = '0;
    endtask

    task automatic request(input logic [4:0] rs1, input logic [4:0] rs2);
        bus.rd_req_i = 1'b1;
        bus.rd_rs1_i = rs1;
        bus.rd_rs2_i = rs2;
    endtask

    task automatic push_rd(input int rd_cyc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2);
        rd_exp_t r;
        r.rd_cyc  = rd_cyc;
        r.vld_cyc = rd_cyc + 1;
        r.rs1     = rs1;
        r.rs2     = rs2;
        r.d1      = d1;
        r.d2      = d2;
        rd_q.push_back(r);
    endtask

    task automatic push_wr(input int wcyc, input logic [4:0] addr, input logic [31:0] data);
        wr_exp_t w;
        w.cyc  = wcyc;
        w.addr = addr;
        w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (wr_q.size() != 0 || rd_q.size() != 0); i++) step();
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d writes %0d reads outstanding expected 0",
                     name, wr_q.size(), rd_q.size());
            wr_q.delete();
            rd_q.delete();
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every input active: all outputs must stay 0.
        rst_n = 1'b0;
        idle_inputs();
        request(5'd3, 5'd4);
        bus.wb_valid_i = 1'b1;
        bus.wb_addr_i  = 5'd2;
        bus.wb_data_i  = 32'h1111;
        bus.md_valid_i = 1'b1;
        bus.md_addr_i  = 5'd6;
        bus.md_data_i  = 32'h2222;
        bus.md_issue_i = 1'b1;
        bus.md_rd_i    = 5'd3;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rd_ack", {31'd0, bus.rd_ack_o}, 32'd0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid_o}, 32'd0);
        chk("rst_wb_ready", {31'd0, bus.wb_ready_o}, 32'd0);
        chk("rst_md_ready", {31'd0, bus.md_ready_o}, 32'd0);
        chk("rst_reg_write", {31'd0, bus.reg_write_o}, 32'd0);
        chk("rst_reg_rd_addr", {27'd0, bus.reg_rd_addr_o}, 32'd0);
        chk("rst_reg_data", bus.reg_data_o, 32'd0);
        chk("rst_reg_read", {31'd0, bus.reg_read_o}, 32'd0);
        chk("rst_rs1_addr", {27'd0, bus.reg_rs1_addr_o}, 32'd0);
        chk("rst_rs2_addr", {27'd0, bus.reg_rs2_addr_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: minimum-latency read, no writes.
        step();
        c = cyc;
        request(5'd3, 5'd4);
        #1 chk("t1_ack", {31'd0, bus.rd_ack_o}, 32'd1);
        push_rd(c + 2, 5'd3, 5'd4, 32'h0, 32'h0);
        step();
        bus.rd_req_i = 1'b0;
        drain("t1");

        // 2: read of a pending mul/div destination waits for the result.
        step();
        bus.md_issue_i = 1'b1;
        bus.md_rd_i    = 5'd5;
        step();
        bus.md_issue_i = 1'b0;
        request(5'd5, 5'd0);
        #1 chk("t2_ack", {31'd0, bus.rd_ack_o}, 32'd1);
        step();
        bus.rd_req_i = 1'b0;
        #1 chk("t2_busy_set", {31'd0, bus.busy_o}, 32'd1);
        step();
        chk("t2_stall_a", {31'd0, bus.reg_read_o}, 32'd0);
        step();
        chk("t2_stall_b", {31'd0, bus.reg_read_o}, 32'd0);
        c = cyc;
        bus.md_valid_i = 1'b1;
        bus.md_addr_i  = 5'd5;
        bus.md_data_i  = 32'hDEADBEEF;
        #1 chk("t2_md_ready", {31'd0, bus.md_ready_o}, 32'd1);
        push_wr(c + 1, 5'd5, 32'hDEADBEEF);
        push_rd(c + 3, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        step();
        bus.md_valid_i = 1'b0;
        step();
        chk("t2_busy_clear", {31'd0, bus.busy_o}, 32'd0);
        drain("t2");

        // 3: simultaneous md and wb writes; md first, wb next cycle.
        step();
        c = cyc;
        bus.wb_valid_i = 1'b1;
        bus.wb_addr_i  = 5'd9;
        bus.wb_data_i  = 32'h99;
        bus.md_valid_i = 1'b1;
        bus.md_addr_i  = 5'd10;
        bus.md_data_i  = 32'hAA;
        #1;
        chk("t3_md_ready", {31'd0, bus.md_ready_o}, 32'd1);
        chk("t3_wb_ready_blocked", {31'd0, bus.wb_ready_o}, 32'd0);
        push_wr(c + 1, 5'd10, 32'hAA);
        step();
        bus.md_valid_i = 1'b0;
        #1 chk("t3_wb_ready", {31'd0, bus.wb_ready_o}, 32'd1);
        push_wr(c + 2, 5'd9, 32'h99);
        step();
        bus.wb_valid_i = 1'b0;
        step();
        request(5'd9, 5'd10);
        push_rd(c + 5, 5'd9, 5'd10, 32'h99, 32'hAA);
        step();
        bus.rd_req_i = 1'b0;
        drain("t3");

        // 4: read of rs2=7 while a wb write to 7 is accepted: one extra cycle.
        step();
        c = cyc;
        request(5'd0, 5'd7);
        bus.wb_valid_i = 1'b1;
        bus.wb_addr_i  = 5'd7;
        bus.wb_data_i  = 32'h77;
        #1;
        chk("t4_ack", {31'd0, bus.rd_ack_o}, 32'd1);
        chk("t4_wb_ready", {31'd0, bus.wb_ready_o}, 32'd1);
        push_wr(c + 1, 5'd7, 32'h77);
        push_rd(c + 3, 5'd0, 5'd7, 32'h0, 32'h77);
        step();
        bus.rd_req_i   = 1'b0;
        bus.wb_valid_i = 1'b0;
        drain("t4");

        // 5: x0 writes from both sources are accepted but never issued.
        step();
        c = cyc;
        bus.md_valid_i = 1'b1;
        bus.md_addr_i  = 5'd0;
        bus.md_data_i  = 32'h1234;
        bus.wb_valid_i = 1'b1;
        bus.wb_addr_i  = 5'd0;
        bus.wb_data_i  = 32'h5678;
        request(5'd0, 5'd9);
        #1;
        chk("t5_md_ready", {31'd0, bus.md_ready_o}, 32'd1);
        chk("t5_wb_ready_blocked", {31'd0, bus.wb_ready_o}, 32'd0);
        chk("t5_ack", {31'd0, bus.rd_ack_o}, 32'd1);
        push_rd(c + 2, 5'd0, 5'd9, 32'h0, 32'h99);
        step();
        bus.md_valid_i = 1'b0;
        bus.rd_req_i   = 1'b0;
        #1;
        chk("t5_wb_ready", {31'd0, bus.wb_ready_o}, 32'd1);
        chk("t5_x0_write_a", {31'd0, bus.reg_write_o}, 32'd0);
        step();
        bus.wb_valid_i = 1'b0;
        chk("t5_x0_write_b", {31'd0, bus.reg_write_o}, 32'd0);
        drain("t5");

        // 6: reset during READ aborts the read and clears the scoreboard.
        step();
        bus.md_issue_i = 1'b1;
        bus.md_rd_i    = 5'd12;
        step();
        bus.md_issue_i = 1'b0;
        request(5'd3, 5'd4);
        step();
        bus.rd_req_i = 1'b0;
        step();
        chk("t6_in_read", {31'd0, bus.reg_read_o}, 32'd1);
        chk("t6_busy_before", {31'd0, bus.busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_reg_read", {31'd0, bus.reg_read_o}, 32'd0);
        chk("t6_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("t6_rst_rs1_addr", {27'd0, bus.reg_rs1_addr_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_rd_valid", {31'd0, bus.rd_valid_o}, 32'd0);
        end
        rst_n = 1'b1;
        step();
        c = cyc;
        request(5'd12, 5'd9);
        #1 chk("t6_ack", {31'd0, bus.rd_ack_o}, 32'd1);
        push_rd(c + 2, 5'd12, 5'd9, 32'h0, 32'h99);
        step();
        bus.rd_req_i = 1'b0;
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32im_regfile_ctrl.md
Name: rv32im_regfile_ctrl

Overview:
- Sequences the RV32IM register file, a dual-BRAM array with no write-through, a read enable, and an address setup of at least half a clock.
- Owns the single write port and arbitrates it between the core writeback path and the multiply/divide unit.
- Keeps a scoreboard of destinations with outstanding mul/div results.
- Issues operand reads only when no write hazard exists.

Parameters:
XLEN, 32, register data width
REG_BITS, 5, register address width (2**REG_BITS registers)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rd_req_i  in  1  operand read request
rd_rs1_i  in  REG_BITS  rs1 address for the request
rd_rs2_i  in  REG_BITS  rs2 address for the request
rd_ack_o  out  1  one-cycle pulse: request captured
rd_valid_o  out  1  one-cycle pulse: register file outputs hold requested operands
wb_valid_i  in  1  core writeback valid
wb_addr_i  in  REG_BITS  core writeback destination
wb_data_i  in  XLEN  core writeback data
wb_ready_o  out  1  core writeback accepted this cycle
md_issue_i  in  1  mul/div op issued; marks md_rd_i pending
md_rd_i  in  REG_BITS  destination of the issued mul/div op
md_valid_i  in  1  mul/div result valid
md_addr_i  in  REG_BITS  mul/div result destination
md_data_i  in  XLEN  mul/div result data
md_ready_o  out  1  mul/div result accepted this cycle
reg_write_o  out  1  register file write enable
reg_rd_addr_o  out  REG_BITS  register file write address
reg_data_o  out  XLEN  register file write data
reg_read_o  out  1  register file read enable (data_ready)
reg_rs1_addr_o  out  REG_BITS  register file rs1 read address
reg_rs2_addr_o  out  REG_BITS  register file rs2 read address
busy_o  out  1  scoreboard non-empty

Behaviour:
- Reset (async, rst_ni low):
  - All outputs 0 and the scoreboard cleared.
  - FSM goes to IDLE. An in-flight read is aborted and rd_valid_o is never produced for it.
- Write arbitration (combinational accept, registered issue):
  - md_ready_o = md_valid_i.
  - wb_ready_o = wb_valid_i & ~md_valid_i. Mul/div has fixed priority; at most one write is accepted per cycle.
  - The accepted write appears on reg_write_o/reg_rd_addr_o/reg_data_o on the next cycle, for exactly one cycle.
  - A write to x0 is accepted (ready high) but reg_write_o stays 0.
- Scoreboard (2**REG_BITS bits; bit 0 is always 0):
  - md_issue_i with a nonzero md_rd_i sets the bit.
  - An accepted md write clears its bit at the same edge.
  - Issue and clear of the same address in the same cycle: set wins.
  - wb writes never touch the scoreboard.
  - busy_o is the registered OR of all bits.
- Read FSM: IDLE, ADDR, READ, DONE.
  - IDLE:
    - rd_ack_o = rd_req_i.
    - On request, latch rs1/rs2 into reg_rs1_addr_o/reg_rs2_addr_o and go to ADDR.
  - ADDR:
    - Addresses are held; reg_read_o = 0.
    - Move to READ only if no hazard; otherwise stay in ADDR.
    - Hazard: a nonzero latched rs1 or rs2 either has its scoreboard bit set, or equals the address of the write accepted in this cycle or the write currently on reg_write_o.
    - This guarantees at least one full setup cycle and no same-edge write/read to the same register.
  - READ: reg_read_o = 1 for one cycle; go to DONE.
  - DONE:
    - rd_valid_o = 1 for one cycle.
    - Addresses remain stable.
    - Go to IDLE. No new request is acknowledged in DONE.
- Minimum latency: request accepted in cycle 0, rd_valid_o in cycle 3.
- x0 operands never cause a hazard.
- A write to a register being read, accepted while in READ or DONE, does not affect the captured operands.

Decomposition:
- Shared package: FSM state encoding (IDLE/ADDR/READ/DONE) and the register-count constant derived from REG_BITS.
- One natural sub-module: rv32im_scoreboard. It contains the set/clear bit vector, the busy flag and two combinational lookup ports.

Test Plan:
1. After reset, rd_req_i with rs1=3, rs2=4 and no writes → rd_ack_o in cycle 0; reg_read_o in cycle 2; rd_valid_o in cycle 3; all outputs 0 during reset.
2. md_issue_i with md_rd_i=5, then a read of rs1=5 → FSM holds in ADDR. After md_valid_i with addr 5, data 0xDEADBEEF: reg_write_o is high with 0xDEADBEEF at that address; reg_read_o follows at least one cycle later; read data = 0xDEADBEEF; busy_o falls.
3. wb_valid_i and md_valid_i in the same cycle → md_ready_o=1 and wb_ready_o=0. The next cycle the md write is issued, then the wb write; no write is lost.
4. A read of rs2=7 while the wb write to address 7 is being accepted → extra ADDR cycle. reg_read_o never coincides with reg_write_o to address 7.
5. Writes to x0 from both sources → ready asserted, reg_write_o stays 0. A read of rs1=0 takes the minimum latency.
6. rst_ni asserted during READ → all outputs 0 immediately and no rd_valid_o. After release, a new request completes in 3 cycles.
